// File: rtl/ga23_palette_mixer.sv
// GA23 palette mixer: tile/sprite priority resolve, palette RAM lookup, 5:5:5 -> 8:8:8 RGB.
// Optional macro PALETTE_BANK_EN adds a second 2048-word bank selected by an I/O register.
module ga23_palette_mixer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic [10:0] tile_color,
   input  logic        tile_prio,
   input  logic [10:0] obj_color,
   input  logic        hblank_in,
   input  logic        vblank_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        mem_cs,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        io_wr,
   input  logic [15:0] addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        busy,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hblank,
   output logic        vblank,
   output logic        hsync,
   output logic        vsync
);

`ifdef PALETTE_BANK_EN
   localparam int PAL_AW = 12;
`else
   localparam int PAL_AW = 11;
`endif
   localparam int PIPE_DLY = 2;

   // state | meaning
   // IDLE  | no CPU access outstanding
   // PEND  | request latched, waiting for a clk with ce=0 to use the RAM port
   // DONE  | RAM access done this cycle, capture read data and release busy
   typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_req;
   logic                w_cpu_go;
   logic [PAL_AW-1:0]   r_cpu_addr;
   logic [15:0]         r_cpu_din;
   logic                r_cpu_wr;
   logic [15:0]         r_cpu_rdata;
   logic [15:0]         r_mem [0:(2**PAL_AW)-1];
   logic [10:0]         w_sel;
   logic [10:0]         r_sel;
   logic [PAL_AW-1:0]   w_vid_idx;
   logic [15:0]         r_vid_rdata;
   logic [3:0]          r_tim [0:PIPE_DLY-1];
   logic                w_blank;

   assign w_req    = mem_cs & (mem_rd | mem_wr);
   assign w_cpu_go = (r_state == ST_PEND) & ~ce;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_req) w_state_nxt = ST_PEND;
         ST_PEND: if (!ce)   w_state_nxt = ST_DONE;
         ST_DONE:            w_state_nxt = ST_IDLE;
         default:            w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cpu_addr  <= '0;
         r_cpu_din   <= '0;
         r_cpu_wr    <= 1'b0;
         r_cpu_rdata <= '0;
         cpu_dout    <= '0;
      end else begin
         if (r_state == ST_IDLE && w_req) begin
            r_cpu_addr <= addr[PAL_AW:1];
            r_cpu_din  <= cpu_din;
            r_cpu_wr   <= mem_wr;
         end
         if (w_cpu_go) r_cpu_rdata <= r_mem[r_cpu_addr];
         if (r_state == ST_DONE) begin
            cpu_dout <= r_cpu_rdata;
            r_cpu_wr <= 1'b0;
         end
      end
   end

   // CPU only touches the RAM on ce=0 clocks, so video reads never collide with a write
   always_ff @(posedge clk) begin
      if (reset_n && w_cpu_go && r_cpu_wr) r_mem[r_cpu_addr] <= r_cpu_din;
   end

`ifdef PALETTE_BANK_EN
   logic r_bank;
   logic w_unused;
   assign w_unused  = &{1'b0, addr[15:13], addr[0]};
   assign w_vid_idx = {r_bank, r_sel};

   always_ff @(posedge clk) begin
      if (!reset_n)                          r_bank <= 1'b0;
      else if (io_wr && addr[7:0] == 8'h02)  r_bank <= cpu_din[1];
   end
`else
   logic w_unused;
   assign w_unused  = &{1'b0, addr[15:12], addr[0], io_wr};
   assign w_vid_idx = r_sel;
`endif

   always_comb begin
      if (tile_prio && tile_color[3:0] != 4'd0) w_sel = tile_color;
      else if (obj_color[3:0] != 4'd0)          w_sel = obj_color;
      else                                      w_sel = tile_color;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sel       <= '0;
         r_vid_rdata <= '0;
         for (int i = 0; i < PIPE_DLY; i++) r_tim[i] <= '0;
      end else if (ce) begin
         r_sel       <= w_sel;
         r_vid_rdata <= r_mem[w_vid_idx];
         r_tim[0]    <= {hblank_in, vblank_in, hsync_in, vsync_in};
         for (int i = 1; i < PIPE_DLY; i++) r_tim[i] <= r_tim[i-1];
      end
   end

   assign w_blank = r_tim[PIPE_DLY-1][3] | r_tim[PIPE_DLY-1][2];

   always_comb begin
      red    = 8'd0;
      green  = 8'd0;
      blue   = 8'd0;
      if (!w_blank) begin
         red   = {r_vid_rdata[4:0],   r_vid_rdata[4:2]};
         green = {r_vid_rdata[9:5],   r_vid_rdata[9:7]};
         blue  = {r_vid_rdata[14:10], r_vid_rdata[14:12]};
      end
      hblank = r_tim[PIPE_DLY-1][3];
      vblank = r_tim[PIPE_DLY-1][2];
      hsync  = r_tim[PIPE_DLY-1][1];
      vsync  = r_tim[PIPE_DLY-1][0];
   end

endmodule

// File: doc/ga23_palette_mixer.md
Name: ga23_palette_mixer

Overview:
- Downstream of the GA23 tilemap stage.
- Merges the tilemap pixel (color index + priority) with the sprite-engine pixel and resolves priority between them.
- Looks up the winning 11-bit index in on-chip palette RAM and drives expanded 8:8:8 RGB with aligned blanking/sync.
- Owns the CPU palette-RAM window, with a busy handshake identical in style to the GA23 VRAM window.

Parameters:
- PAL_AW, 11, palette RAM word-address width (2048 x 16); becomes 12 when PALETTE_BANK_EN is defined.
- PIPE_DLY, 2, pixel (ce) delay from input pixel to RGB output; fixed, not for override.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ce  in  1  pixel clock enable
- tile_color  in  11  tilemap palette index; [3:0]==0 means transparent
- tile_prio  in  1  tilemap over-sprite priority
- obj_color  in  11  sprite palette index; [3:0]==0 means transparent
- hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  timing from the tilemap stage
- mem_cs, mem_rd, mem_wr  in  1 each  CPU palette window strobes (single-cycle pulses)
- io_wr  in  1  CPU I/O write strobe
- addr  in  16  CPU byte address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data
- busy  out  1  CPU access pending
- red, green, blue  out  8 each  pixel colour
- hblank, vblank, hsync, vsync  out  1 each  timing delayed to match RGB

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs 0; busy 0.
  - Pipeline registers and the access FSM are cleared.
  - Palette RAM contents are not cleared.
  - A reset asserted mid-access abandons the access; busy drops on the next edge.
- Mix stage (on ce, stage 1):
  - If tile_prio=1 and tile_color[3:0]!=0: select tile_color.
  - Else if obj_color[3:0]!=0: select obj_color.
  - Else: select tile_color (background, transparent or not).
  - Register the selected index together with the four timing inputs.
- Lookup stage (on ce, stage 2): palette RAM read at the registered index; timing is delayed one more stage.
- Output stage:
  - RAM word is xBBBBBGGGGGRRRRR.
  - red = {R, R[4:2]}, green = {G, G[4:2]}, blue = {B, B[4:2]}.
  - While the delayed hblank|vblank is 1, RGB is forced to 0.
  - Total latency is exactly PIPE_DLY ce pulses from input to RGB/timing outputs.
  - Outputs hold between ce pulses.
- CPU access FSM (states IDLE, PEND, DONE):
  - IDLE→PEND on mem_cs & (mem_rd|mem_wr); latch addr[PAL_AW:1], cpu_din and the write flag. busy = (state != IDLE).
  - PEND→DONE on the first clk where ce=0, so the palette RAM port is free of video reads. In that cycle, perform the write (full 16 bits) or issue the read.
  - DONE→IDLE on the next clk. cpu_dout is captured from RAM output, and the write flag is cleared.
  - A new request while busy is ignored (the CPU waits on busy).
  - If ce is held high continuously, PEND waits. The bench guarantees ce duty ≤ 1/2.
- Simultaneous video read and CPU write to the same word: the video sees the old data that pixel; the new data is visible from the next ce.
- addr bits above PAL_AW are ignored (window mirrors).

Optional Feature:
- Macro: PALETTE_BANK_EN.
- Defined:
  - PAL_AW=12 (4096 words).
  - A 1-bit bank register, reset 0, is set by io_wr when addr[7:0]=='h02, taking cpu_din[1].
  - The video lookup index becomes {bank, selected[10:0]}.
  - The CPU window uses addr[12:1] directly (both banks visible).
- Undefined:
  - 2048 words, no bank register, io_wr ignored.
  - CPU uses addr[11:1].

Test Plan:
- Reset: hold reset_n=0 for 4 clk with ce toggling → RGB=0, busy=0, all timing outputs 0.
- CPU write/read: write 16'h7FFF to byte addr 0x0022, then read it back → busy high 2–3 clk per access; cpu_dout=16'h7FFF.
- Priority and colour: palette[0x013]=16'h001F, palette[0x025]=16'h7C00.
  - tile=0x013, prio=0, obj=0x025 → blue=8'hFF, red=0, green=0, two ce later.
  - Same inputs with prio=1 → red=8'hFF.
  - tile=0x010, obj=0x020, prio=1 → lookup 0x010 (tile background).
- Blanking alignment: pulse hblank_in for 3 ce with opaque pixels → hblank out shifted exactly 2 ce; RGB=0 over exactly those 3 pixels.
- Contention: issue a CPU write to index 0x013 while continuously displaying 0x013 at ce every other clk → old colour until the write completes; new colour from the next ce; no dropped pixel.
- Bank (PALETTE_BANK_EN): io_wr addr 0x02 din 0x0002; palette[0x813]=16'h03E0; tile=0x013 → green=8'hFF. Without the macro, same stimulus → colour of palette[0x013].
